spi_slave_interface: RTL

Mode-0 SPI responder: the far end of the team's 8-bit SPI master, used when the FPGA is itself a peripheral on an SPI bus. It oversamples SCLK/CS/MOSI in the local `clk` domain and deserialises MOSI into bytes. It serialises a host-supplied byte onto MISO, MSB first. Bytes are exchanged with local logic via a one-entry transmit buffer (valid/ready) and a one-cycle receive strobe.

---
 rtl/spi_slave_interface_if.sv | 30 +++
 rtl/spi_slave_interface.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_interface_if.sv
// Signal bundle between the SPI responder and its neighbours: the SPI pins
// plus the local transmit-buffer / receive-strobe handshake.
interface spi_slave_interface_if;
    // SPI pins
    logic       SCLK;
    logic       CS;
    logic       MOSI;
    logic       MISO;
    // Local transmit buffer handshake
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    // Local receive side and status
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    // The SPI responder itself
    modport slave (
        input  SCLK, CS, MOSI, tx_data, tx_valid,
        output MISO, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    // Whoever drives the bus and the transmit buffer (SPI master plus host logic)
    modport master (
        output SCLK, CS, MOSI, tx_data, tx_valid,
        input  MISO, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave_interface.sv
// Mode-0 SPI responder. SCLK/CS/MOSI are oversampled in the clk domain,
// MOSI is deserialised MSB first into rx_data, and a host-supplied byte
// (one-entry buffer, or 0x00 on underrun) is shifted out on MISO.
module spi_slave_interface #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_slave_interface_if.slave  io_bus
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [1:0] FLUSH_DONE = 2'(SYNC_STAGES);

    // Synchroniser chains and history flops
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_hist;
    logic                   r_cs_hist;
    logic                   r_mosi_hist;

    // After reset the chains hold reset values, not pin values; CS falls are
    // only honoured once the chain is flushed and CS has been seen high, so a
    // frame already in progress at reset release is ignored.
    logic [1:0]             r_flush_cnt;
    logic                   r_armed;

    // Transmit buffer
    logic [7:0]             r_buf;
    logic                   r_full;
    logic                   r_tx_underrun;

    // Frame state
    state_t                 r_state;
    logic [3:0]             r_bit_cnt;
    logic [7:0]             r_rx_sh;
    logic [7:0]             r_tx_sh;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_miso;
    logic                   r_busy;

    // Decoded events
    logic                   w_sclk_s;
    logic                   w_cs_s;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic                   w_write;
    logic                   w_load;
    logic [7:0]             w_load_byte;
    logic [7:0]             w_rx_next;

    // Synchronise the pins, keep one history sample and track flush/arming
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // updates from the values present before the clock edge.
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_hist <= 1'b0;
            r_cs_hist   <= 1'b1;
            r_mosi_hist <= 1'b0;
            r_flush_cnt <= 2'd0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_bus.SCLK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   io_bus.CS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], io_bus.MOSI};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_hist   <= r_cs_sync[SYNC_STAGES-1];
            r_mosi_hist <= r_mosi_sync[SYNC_STAGES-1];
            if (r_flush_cnt != FLUSH_DONE) begin
                r_flush_cnt <= r_flush_cnt + 2'd1;
            end else if (w_cs_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Edge detection, buffer write qualification and byte-load selection
    always_comb begin
        // NOTE: every signal gets a default at the top of the block so no
        // path can leave it unassigned and infer a latch.
        w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
        w_cs_s      = r_cs_sync[SYNC_STAGES-1];
        w_sclk_rise = w_sclk_s & ~r_sclk_hist;
        w_sclk_fall = ~w_sclk_s & r_sclk_hist;
        w_cs_rise   = w_cs_s & ~r_cs_hist;
        w_cs_fall   = ~w_cs_s & r_cs_hist & r_armed;
        w_write     = io_bus.tx_valid & ~r_full;
        w_load      = 1'b0;
        // The MOSI history sample lines up with the SCLK edge seen between
        // the last sync stage and the SCLK history flop.
        w_rx_next   = {r_rx_sh[6:0], r_mosi_hist};

        if (r_state == IDLE) begin
            w_load = w_cs_fall;
        end else begin
            w_load = ~w_cs_rise & ~w_cs_fall & w_sclk_fall & (r_bit_cnt == 4'd8);
        end

        if (r_full) begin
            w_load_byte = r_buf;
        end else if (w_write) begin
            w_load_byte = io_bus.tx_data;
        end else begin
            w_load_byte = 8'h00;
        end
    end

    // One-entry transmit buffer: filled by a write, drained by a byte load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf         <= 8'h00;
            r_full        <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= w_load & ~r_full & ~w_write;
            if (w_load) begin
                // A write coinciding with a load from an empty buffer bypasses
                // into the shift register and leaves the buffer empty.
                r_full <= 1'b0;
            end else if (w_write) begin
                r_buf  <= io_bus.tx_data;
                r_full <= 1'b1;
            end
        end
    end

    // Frame FSM: shift MOSI in on SCLK rise, MISO out on SCLK fall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= 4'd0;
            r_rx_sh    <= 8'h00;
            r_tx_sh    <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_miso     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_miso     <= (r_state == ACTIVE) ? r_tx_sh[7] : 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state   <= ACTIVE;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= 4'd0;
                        r_tx_sh   <= w_load_byte;
                    end
                end
                ACTIVE: begin
                    if (w_cs_rise) begin
                        // Partial bytes and an already-loaded tx byte are dropped.
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_bit_cnt <= 4'd0;
                    end else if (w_cs_fall) begin
                        r_state   <= ACTIVE;
                    end else if (w_sclk_rise && r_bit_cnt != 4'd8) begin
                        r_rx_sh   <= w_rx_next;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            r_tx_sh   <= w_load_byte;
                            r_bit_cnt <= 4'd0;
                        end else begin
                            r_tx_sh   <= {r_tx_sh[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.MISO        = r_miso;
    assign io_bus.tx_ready    = ~r_full;
    assign io_bus.rx_data     = r_rx_data;
    assign io_bus.rx_valid    = r_rx_valid;
    assign io_bus.tx_underrun = r_tx_underrun;
    assign io_bus.busy        = r_busy;

endmodule
